time_display: RTL and testbench

Downstream consumer of the clock core: takes the binary `hours`/`minutes`/`seconds`/`am_pm` time and the `setting_h`/`setting_m` mode flags. Drives a six-digit, time-multiplexed, common-anode 7-segment display (HH MM SS) with a PM indicator and blinking of the field being set. Runs entirely on the fast system clock `clk`; it never uses `clk_1hz`.

---
 rtl/display_pkg.sv | 56 +++++
 rtl/seg7_decode.sv | 25 ++
 rtl/time_display.sv | 126 ++++++++++++
 tb/tb_time_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the six-digit multiplexed time display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package display_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [2:0] D_S1  = 3'd0;
  localparam logic [2:0] D_S10 = 3'd1;
  localparam logic [2:0] D_M1  = 3'd2;
  localparam logic [2:0] D_M10 = 3'd3;
  localparam logic [2:0] D_H1  = 3'd4;
  localparam logic [2:0] D_H10 = 3'd5;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;

  typedef struct packed {
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       setting_h;
    logic       setting_m;
  } snap_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Repeated compare/subtract; six steps cover the full 6-bit range.
  function automatic bcd_t bcd_split(input logic [5:0] v);
    bcd_t       r;
    logic [5:0] rem;
    rem    = v;
    r.tens = 4'd0;
    for (int k = 0; k < 6; k++) begin
      if (rem >= 6'd10) begin
        rem    = rem - 6'd10;
        r.tens = r.tens + 4'd1;
      end
    end
    r.units = 4'(rem);
    return r;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern; codes above 9 select blank or dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg_n
);
  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_code)
      4'd0:       o_seg_n = SEG_0;
      4'd1:       o_seg_n = SEG_1;
      4'd2:       o_seg_n = SEG_2;
      4'd3:       o_seg_n = SEG_3;
      4'd4:       o_seg_n = SEG_4;
      4'd5:       o_seg_n = SEG_5;
      4'd6:       o_seg_n = SEG_6;
      4'd7:       o_seg_n = SEG_7;
      4'd8:       o_seg_n = SEG_8;
      4'd9:       o_seg_n = SEG_9;
      CODE_DASH:  o_seg_n = SEG_DASH;
      default:    o_seg_n = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/time_display.sv
// Six-digit HH MM SS multiplexed display driver with PM point and set-field blink.
// Inputs are captured once per frame so a frame never mixes two times.
module time_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       am_pm,
  input  logic       setting_h,
  input  logic       setting_m,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_digit;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;
  snap_t         r_snap;
  logic          r_load_pend;

  logic       w_scan_wrap, w_load, w_guard;
  logic       w_h_ok, w_m_ok, w_s_ok, w_blank_h, w_blank_m;
  bcd_t       w_h, w_m, w_s;
  logic [3:0] w_code;
  logic [6:0] w_seg;

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_load      = r_load_pend | (w_scan_wrap && (r_digit == D_H10));
  assign w_guard     = (r_scan_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= D_S1;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_digit    <= (r_digit == D_H10) ? D_S1 : r_digit + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap      <= '0;
      r_load_pend <= 1'b1;
    end else begin
      r_load_pend <= 1'b0;
      if (w_load) r_snap <= {hours, minutes, seconds, am_pm, setting_h, setting_m};
    end
  end

  assign w_h       = bcd_split({2'b00, r_snap.hours});
  assign w_m       = bcd_split(r_snap.minutes);
  assign w_s       = bcd_split(r_snap.seconds);
  assign w_h_ok    = (r_snap.hours != 4'd0) && (r_snap.hours <= 4'd12);
  assign w_m_ok    = (r_snap.minutes <= 6'd59);
  assign w_s_ok    = (r_snap.seconds <= 6'd59);
  assign w_blank_h = ~r_blink_on & r_snap.setting_h;
  assign w_blank_m = ~r_blink_on & r_snap.setting_m;

  // Priority per digit: blink blank, then invalid dash, then leading-zero blank.
  always_comb begin
    w_code = CODE_BLANK;
    case (r_digit)
      D_S1:  w_code = w_s_ok ? w_s.units : CODE_DASH;
      D_S10: w_code = w_s_ok ? w_s.tens  : CODE_DASH;
      D_M1:  w_code = w_blank_m ? CODE_BLANK : (w_m_ok ? w_m.units : CODE_DASH);
      D_M10: w_code = w_blank_m ? CODE_BLANK : (w_m_ok ? w_m.tens  : CODE_DASH);
      D_H1:  w_code = w_blank_h ? CODE_BLANK : (w_h_ok ? w_h.units : CODE_DASH);
      D_H10: begin
        if (w_blank_h)              w_code = CODE_BLANK;
        else if (!w_h_ok)           w_code = CODE_DASH;
        else if (w_h.tens == 4'd0)  w_code = CODE_BLANK;
        else                        w_code = w_h.tens;
      end
      default: w_code = CODE_BLANK;
    endcase
  end

  seg7_decode u_dec (
    .i_code  (w_code),
    .o_seg_n (w_seg)
  );

  // First cycle of every slot keeps all anodes off to avoid ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n  <= 6'h3F;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else if (w_guard) begin
      an_n  <= 6'h3F;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= ~(6'b000001 << r_digit);
      seg_n <= w_seg;
      dp_n  <= ~((r_digit == D_H1) & r_snap.am_pm);
    end
  end
endmodule

// File: tb/tb_time_display.sv
// Randomized and directed bench for time_display against a frame-level timing model.
module tb_time_display;
  localparam int SD = 4;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hours = 4'd12;
  logic [5:0] minutes = 6'd34;
  logic [5:0] seconds = 6'd56;
  logic       am_pm = 1'b1;
  logic       setting_h = 1'b0;
  logic       setting_m = 1'b0;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int nvec = 0;
  int nmis = 0;

  time_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .hours(hours), .minutes(minutes), .seconds(seconds),
    .am_pm(am_pm), .setting_h(setting_h), .setting_m(setting_m),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Model state: edges since reset release and the frame-captured inputs.
  int   e = 0;
  int   sh, sm, ss;
  bit   spm, ssh, ssm;
  bit   exp_rst = 1'b1, exp_guard;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic logic [6:0] model_seg(input int d, input bit bon);
    bit hv, mv, sv, hb, mb;
    hv = (sh >= 1) && (sh <= 12);
    mv = (sm <= 59);
    sv = (ss <= 59);
    hb = !bon && ssh;
    mb = !bon && ssm;
    case (d)
      0: return sv ? pat[ss % 10] : 7'h3F;
      1: return sv ? pat[ss / 10] : 7'h3F;
      2: return mb ? 7'h7F : (mv ? pat[sm % 10] : 7'h3F);
      3: return mb ? 7'h7F : (mv ? pat[sm / 10] : 7'h3F);
      4: return hb ? 7'h7F : (hv ? pat[sh % 10] : 7'h3F);
      default: return hb ? 7'h7F : (!hv ? 7'h3F : (sh < 10 ? 7'h7F : pat[sh / 10]));
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e = 0;
      exp_rst = 1'b1;
    end else begin
      int p, d;
      p = e;
      d = (p / SD) % 6;
      exp_rst   = 1'b0;
      exp_guard = (p % SD) == 0;
      exp_an    = 6'h3F & ~(6'd1 << d);
      exp_seg   = model_seg(d, ((p / BD) % 2) == 0);
      exp_dp    = !(d == 4 && spm);
      e++;
      if (e == 1 || e % (6 * SD) == 0) begin
        sh = hours; sm = minutes; ss = seconds;
        spm = am_pm; ssh = setting_h; ssm = setting_m;
      end
    end
  end

  always @(negedge clk) begin
    bit bad;
    nvec++;
    if (exp_rst || exp_guard)
      bad = (an_n !== 6'h3F) || (dp_n !== 1'b1) || (exp_rst && seg_n !== 7'h7F);
    else
      bad = (an_n !== exp_an) || (seg_n !== exp_seg) || (dp_n !== exp_dp);
    if (bad) begin
      nmis++;
      $display("FAIL model t=%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b (rst=%0b guard=%0b)",
               $time, an_n, seg_n, dp_n, (exp_rst || exp_guard) ? 6'h3F : exp_an,
               exp_rst ? 7'h7F : exp_seg, (exp_rst || exp_guard) ? 1'b1 : exp_dp,
               exp_rst, exp_guard);
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", nm, act, expv);
    end
  endtask

  task automatic wait_an(input logic [5:0] v);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (an_n == v) found = 1'b1;
    end
    if (!found) chk("wait_an_timeout", an_n, v);
  endtask

  task automatic release_and_pin(input bit pin_seg);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1 || k == 5) chk("guard_after_release", an_n, 6'h3F);
      if (k >= 2 && k <= 4) chk("digit0_first_slot", an_n, 6'h3E);
      if (pin_seg) begin
        if (k == 2)  chk("s_units_6", seg_n, 7'h02);
        if (k == 18) begin
          chk("h_units_an", an_n, 6'h2F);
          chk("h_units_2", seg_n, 7'h24);
          chk("pm_dp", dp_n, 0);
        end
        if (k == 22) chk("h_tens_1", seg_n, 7'h79);
      end
    end
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit pm);
    hours = 4'(h); minutes = 6'(m); seconds = 6'(s); am_pm = pm;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_an", an_n, 6'h3F);
      chk("reset_seg", seg_n, 7'h7F);
      chk("reset_dp", dp_n, 1);
    end
    release_and_pin(1'b1);

    set_time(9, 5, 0, 1'b0);
    repeat (30) @(negedge clk);
    wait_an(6'h1F); chk("lead_zero_blank", seg_n, 7'h7F);
    wait_an(6'h2F); chk("h_units_9", seg_n, 7'h10); chk("am_dp", dp_n, 1);
    wait_an(6'h37); chk("m_tens_0", seg_n, 7'h40);
    wait_an(6'h3B); chk("m_units_5", seg_n, 7'h12);

    setting_h = 1'b1; repeat (300) @(negedge clk);
    setting_h = 1'b0; setting_m = 1'b1; repeat (300) @(negedge clk);
    setting_m = 1'b0;

    set_time(11, 33, 20, 1'b1);
    repeat (30) @(negedge clk);
    wait_an(6'h3D);
    minutes = 6'd34;
    wait_an(6'h3B); chk("mid_frame_old_min", seg_n, 7'h30);
    wait_an(6'h1F);
    wait_an(6'h3B); chk("next_frame_new_min", seg_n, 7'h19);

    set_time(0, 7, 60, 1'b0);
    repeat (30) @(negedge clk);
    wait_an(6'h1F); chk("dash_h10", seg_n, 7'h3F);
    wait_an(6'h2F); chk("dash_h1", seg_n, 7'h3F);
    wait_an(6'h3E); chk("dash_s1", seg_n, 7'h3F);
    wait_an(6'h3D); chk("dash_s10", seg_n, 7'h3F);

    set_time(10, 59, 59, 1'b1);
    repeat (30) @(negedge clk);
    wait_an(6'h37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", an_n, 6'h3F);
    chk("async_rst_seg", seg_n, 7'h7F);
    chk("async_rst_dp", dp_n, 1);
    repeat (3) @(negedge clk);
    release_and_pin(1'b0);

    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        hours     = 4'($urandom_range(0, 15));
        minutes   = 6'($urandom_range(0, 63));
        seconds   = 6'($urandom_range(0, 63));
        am_pm     = 1'($urandom_range(0, 1));
        setting_h = ($urandom_range(0, 2) == 0);
        setting_m = ($urandom_range(0, 2) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
